// File: rtl/bin_to_bcd_seg.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seg
//
// Sequential binary-to-BCD formatter sitting between the I2C ADC reader
// (rd_data) and Seg_Display (seg_val). An unsigned sample is accepted over a
// valid/ready handshake and converted by iterative double-dabble (add-3 then
// shift), one input bit per clock. The result is packed into an 8-nibble
// display word: prefix symbol in nibble 7, unused nibbles blanked, digits
// right-justified with leading-zero blanking (the units digit is never
// blanked).
//
// Handshake: a sample transfers on a rising edge of sys_clk where both
// bin_vld and bin_rdy are high. bin_rdy is high only in IDLE. bin_vld seen
// while busy is ignored, not queued. seg_data_vld is a one-cycle pulse
// with no back-pressure; seg_data holds its value between updates.
//
// Ports
//   sys_clk       in   1      system clock, rising edge
//   sys_rst       in   1      synchronous reset, active high
//   bin_in        in   BIN_W  unsigned sample
//   bin_vld       in   1      bin_in valid
//   bin_rdy       out  1      ready to accept a sample
//   seg_data      out  32     {nib7..nib0} display word
//   seg_data_vld  out  1      one-cycle pulse: seg_data freshly updated
//   busy          out  1      conversion in progress (= ~bin_rdy)
//   dbg_state     out  2      current FSM state, for observation only
//
// Timing (accept edge = edge 0): BIN_W SHIFT cycles, seg_data written on
// edge BIN_W+1, seg_data_vld high in the following cycle, bin_rdy back
// after edge BIN_W+2. One sample per BIN_W+3 cycles.
// ----------------------------------------------------------------------------
module bin_to_bcd_seg #(
    parameter int         BIN_W       = 8,
    parameter int         DIGITS      = 3,
    parameter logic [3:0] PREFIX_CODE = 4'd15,
    parameter logic [3:0] BLANK_CODE  = 4'd10
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_vld,
    output logic             bin_rdy,
    output logic [31:0]      seg_data,
    output logic             seg_data_vld,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [63:0] MAX_IN = (64'd1 << BIN_W) - 64'd1;
    localparam logic [31:0] SEG_RESET = {PREFIX_CODE, {7{BLANK_CODE}}};

    // The largest input must fit in DIGITS decimal digits, and the digits
    // must fit below the prefix nibble.
    if (DIGITS < 1 || DIGITS > 7 || (64'd10 ** DIGITS) <= MAX_IN) begin : g_param_check
        $error("bin_to_bcd_seg: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, BIN_W);
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        seg_q, seg_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [31:0]        fmt_word;

    // Double-dabble correction: any digit >= 5 gets +3 so that the following
    // left shift carries correctly into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking, scanning from the most significant digit.
    // Once a nonzero digit (or the units digit) is reached, every digit below
    // it is shown, so inner zeros survive.
    always_comb begin
        logic       seen;
        logic [3:0] dig;
        fmt_word = SEG_RESET;
        seen     = 1'b0;
        dig      = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = bcd_q[4*i +: 4];
            if (dig != 4'd0 || i == 0) begin
                seen = 1'b1;
            end
            fmt_word[4*i +: 4] = seen ? dig : BLANK_CODE;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (bin_vld) begin
                    sh_d    = bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // MSB of the sample register enters bcd bit 0.
                {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                seg_d   = fmt_word;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= SEG_RESET;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
        end
    end

    assign bin_rdy      = (state_q == ST_IDLE);
    assign busy         = ~bin_rdy;
    assign seg_data_vld = (state_q == ST_OUT);
    assign seg_data     = seg_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seg.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seg
//
// Directed bench for bin_to_bcd_seg at default parameters (BIN_W=8,
// DIGITS=3). Inputs are driven 1 time unit after a rising edge; outputs are
// sampled at the same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seg;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  bin_in;
    logic        bin_vld;
    logic        bin_rdy;
    logic [31:0] seg_data;
    logic        seg_data_vld;
    logic        busy;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_errors;
    logic [31:0] prev_seg;
    logic [31:0] exp_q[$];

    bin_to_bcd_seg dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .bin_in       (bin_in),
        .bin_vld      (bin_vld),
        .bin_rdy      (bin_rdy),
        .seg_data     (seg_data),
        .seg_data_vld (seg_data_vld),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference word: / and % based, independent of the shift-add scheme.
    function automatic logic [31:0] ref_word(input int v);
        logic [3:0] d2, d1, d0;
        d0 = 4'(v % 10);
        d1 = (v >= 10)  ? 4'((v / 10) % 10) : 4'hA;
        d2 = (v >= 100) ? 4'(v / 100)       : 4'hA;
        return {20'hFAAAA, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_rdy();
        int guard;
        guard = 0;
        while (!bin_rdy && guard < 20) begin
            tick();
            guard++;
        end
        check("rdy_wait", {31'd0, bin_rdy}, 32'd1);
    endtask

    // One full conversion with latency checks around the output edge.
    task automatic convert(input logic [7:0] v, input logic [31:0] exp);
        wait_rdy();
        bin_in  = v;
        bin_vld = 1'b1;
        tick();                         // edge 0: accept
        bin_vld = 1'b0;
        bin_in  = 8'($urandom_range(0, 255));
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("rdy_after_accept", {31'd0, bin_rdy}, 32'd0);
        repeat (8) tick();              // after edge 8
        check("seg_held_edge8", seg_data, prev_seg);
        check("vld_low_edge8", {31'd0, seg_data_vld}, 32'd0);
        tick();                         // after edge 9
        check("seg_data", seg_data, exp);
        check("vld_pulse", {31'd0, seg_data_vld}, 32'd1);
        check("rdy_low_out", {31'd0, bin_rdy}, 32'd0);
        tick();                         // after edge 10
        check("vld_drop", {31'd0, seg_data_vld}, 32'd0);
        check("rdy_back", {31'd0, bin_rdy}, 32'd1);
        prev_seg = exp;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  dir_val [8] = '{8'd0, 8'd7, 8'd42, 8'd42, 8'd255, 8'd100, 8'd205, 8'd99};
    logic [31:0] dir_exp [8] = '{32'hFAAA_AAA0, 32'hFAAA_AAA7, 32'hFAAA_AA42, 32'hFAAA_AA42,
                                 32'hFAAA_A255, 32'hFAAA_A100, 32'hFAAA_A205, 32'hFAAA_AA99};
    int          acc_cyc [3] = '{0, 11, 22};

    initial begin
        int n_acc;
        int n_pulse;
        logic [31:0] exp_w;

        n_checks = 0;
        n_errors = 0;
        sys_rst  = 1'b1;
        bin_vld  = 1'b0;
        bin_in   = 8'd0;
        prev_seg = 32'hFAAA_AAAA;

        // reset
        repeat (3) tick();
        check("rst_seg", seg_data, 32'hFAAA_AAAA);
        check("rst_rdy", {31'd0, bin_rdy}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_vld", {31'd0, seg_data_vld}, 32'd0);
        sys_rst = 1'b0;
        tick();

        // directed values, including a repeated sample and inner zeros
        for (int i = 0; i < 8; i++) begin
            convert(dir_val[i], dir_exp[i]);
        end

        // bin_vld held high with bin_in stepping every cycle
        wait_rdy();
        n_acc   = 0;
        n_pulse = 0;
        for (int c = 0; c < 33; c++) begin
            bin_in  = 8'(10 + c);
            bin_vld = 1'b1;
            if (bin_rdy) begin
                if (n_acc < 3) begin
                    check("stream_accept_cycle", 32'(c), 32'(acc_cyc[n_acc]));
                end
                exp_q.push_back(ref_word(10 + c));
                n_acc++;
            end
            tick();
            if (seg_data_vld) begin
                n_pulse++;
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_vld", 32'd1, 32'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("stream_seg", seg_data, exp_w);
                end
            end
        end
        bin_vld = 1'b0;
        check("stream_accepts", 32'(n_acc), 32'd3);
        check("stream_pulses", 32'(n_pulse), 32'd3);
        check("stream_last_word", seg_data, 32'hFAAA_AA32);
        prev_seg = 32'hFAAA_AA32;

        // reset in the middle of a conversion of 200
        wait_rdy();
        bin_in  = 8'd200;
        bin_vld = 1'b1;
        tick();
        bin_vld = 1'b0;
        repeat (4) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("abort_seg", seg_data, 32'hFAAA_AAAA);
        check("abort_vld", {31'd0, seg_data_vld}, 32'd0);
        check("abort_rdy", {31'd0, bin_rdy}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        n_pulse = 0;
        repeat (12) begin
            tick();
            if (seg_data_vld) n_pulse++;
        end
        check("abort_no_pulse", 32'(n_pulse), 32'd0);
        check("abort_seg_held", seg_data, 32'hFAAA_AAAA);
        prev_seg = 32'hFAAA_AAAA;
        convert(8'd9, 32'hFAAA_AAA9);

        // exhaustive sweep against the / and % model
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), ref_word(v));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
